pe_2d_mb: RTL and testbench



---
 rtl/pe_2d_mb.sv | 227 ++++++++++++++++++++++
 tb/tb_pe_2d_mb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_2d_mb.sv
// pe_2d_mb - weight-stationary systolic processing element with a weight bank.
//
// A daisy-chained shadow register receives weights from the PE above and is
// committed into one of W_DEPTH bank slots. Every feature sample carries a
// valid bit and a slot select, so several kernels can share one array.
// Stage 1 registers the feature-side inputs and the incoming psum. Stage 2
// multiplies, accumulates and optionally saturates. Instances tile into an
// RxC array: weights shift down, features move right, psums move down.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   w_load, w_in / w_out        shadow weight capture and daisy-chain output
//   w_commit_in, w_addr_in      commit shadow into bank[w_addr_in]
//   w_commit_out, w_addr_out    commit request forwarded one cycle later
//   fm_valid_in, fm_in, w_sel_in        feature sample and its bank slot
//   fm_valid_out, fm_out, w_sel_out     stage-1 copies to the right neighbour
//   psum_in                     partial sum from above
//   psum_valid_out, psum_out    registered MAC result to the PE below
//   ovf_clr, ovf                sticky overflow flag and its synchronous clear
module pe_2d_mb #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 20,
  parameter int unsigned W_DEPTH = 4,
  parameter bit          SIGNED  = 1'b1,
  parameter bit          SAT     = 1'b1,
  localparam int unsigned SEL_W  = (W_DEPTH > 1) ? $clog2(W_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_load,
  input  logic [DATA_W-1:0] w_in,
  output logic [DATA_W-1:0] w_out,
  input  logic              w_commit_in,
  input  logic [SEL_W-1:0]  w_addr_in,
  output logic              w_commit_out,
  output logic [SEL_W-1:0]  w_addr_out,
  input  logic              fm_valid_in,
  input  logic [DATA_W-1:0] fm_in,
  input  logic [SEL_W-1:0]  w_sel_in,
  output logic              fm_valid_out,
  output logic [DATA_W-1:0] fm_out,
  output logic [SEL_W-1:0]  w_sel_out,
  input  logic [ACC_W-1:0]  psum_in,
  output logic              psum_valid_out,
  output logic [ACC_W-1:0]  psum_out,
  input  logic              ovf_clr,
  output logic              ovf
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  // Two guard bits hold the exact sum of an ACC_W psum and a PROD_W product.
  localparam int unsigned EXT_W  = ACC_W + 2;

  // True when a slot address refers to a physical bank entry.
  function automatic logic slot_ok(input logic [SEL_W-1:0] a);
    return (32'(a) < W_DEPTH);
  endfunction

  // Extend a psum to the guarded width according to operand signedness.
  function automatic logic [EXT_W-1:0] ext_acc(input logic [ACC_W-1:0] v);
    if (SIGNED) begin
      return {{2{v[ACC_W-1]}}, v};
    end else begin
      return {2'b00, v};
    end
  endfunction

  // Extend a full-width product to the guarded width.
  function automatic logic [EXT_W-1:0] ext_prod(input logic [PROD_W-1:0] p);
    if (SIGNED) begin
      return {{(EXT_W-PROD_W){p[PROD_W-1]}}, p};
    end else begin
      return {{(EXT_W-PROD_W){1'b0}}, p};
    end
  endfunction

  // Full 2*DATA_W product; operands are pre-extended so the low PROD_W bits
  // of the unsigned multiply are the exact two's-complement result.
  function automatic logic [PROD_W-1:0] mul(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [PROD_W-1:0] ea;
    logic [PROD_W-1:0] eb;
    if (SIGNED) begin
      ea = {{DATA_W{a[DATA_W-1]}}, a};
      eb = {{DATA_W{b[DATA_W-1]}}, b};
    end else begin
      ea = {{DATA_W{1'b0}}, a};
      eb = {{DATA_W{1'b0}}, b};
    end
    return ea * eb;
  endfunction

  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [DATA_W-1:0] bank_q [W_DEPTH];
  logic [DATA_W-1:0] bank_d [W_DEPTH];
  logic              commit_q, commit_d;
  logic [SEL_W-1:0]  addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] fm_q, fm_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [ACC_W-1:0]  psum_in_q, psum_in_d;
  logic [ACC_W-1:0]  psum_out_q, psum_out_d;
  logic              psum_valid_q, psum_valid_d;
  logic              ovf_q, ovf_d;

  logic [DATA_W-1:0] weight_s;
  logic [EXT_W-1:0]  sum_s;
  logic              oor_s;
  logic [ACC_W-1:0]  clamp_s;
  logic [ACC_W-1:0]  mac_s;

  // Weight path: shadow capture, bank commit and commit-wave forwarding.
  always_comb begin
    shadow_d = shadow_q;
    bank_d   = bank_q;
    if (w_load) begin
      shadow_d = w_in;
    end else begin
      shadow_d = shadow_q;
    end
    // Out-of-range commit addresses write nothing but are still forwarded.
    if (w_commit_in && slot_ok(w_addr_in)) begin
      bank_d[w_addr_in] = shadow_q;
    end else begin
      bank_d = bank_q;
    end
    commit_d = w_commit_in;
    addr_d   = w_addr_in;
  end

  // Stage 1: capture feature sample, slot select and incoming psum.
  always_comb begin
    valid_d   = fm_valid_in;
    fm_d      = fm_in;
    sel_d     = w_sel_in;
    psum_in_d = psum_in;
  end

  // Stage 2: multiply-accumulate with range detection and optional clamp.
  always_comb begin
    weight_s = {DATA_W{1'b0}};
    oor_s    = 1'b0;
    clamp_s  = {ACC_W{1'b0}};
    // The bank is read before any same-edge commit lands, so a colliding
    // commit only affects later samples.
    if (slot_ok(sel_q)) begin
      weight_s = bank_q[sel_q];
    end else begin
      weight_s = {DATA_W{1'b0}};
    end
    sum_s = ext_acc(psum_in_q) + ext_prod(mul(weight_s, fm_q));
    if (SIGNED) begin
      // In range only when every bit from the ACC_W sign bit upward agrees.
      oor_s = !((sum_s[EXT_W-1:ACC_W-1] == {(EXT_W-ACC_W+1){1'b0}}) ||
                (sum_s[EXT_W-1:ACC_W-1] == {(EXT_W-ACC_W+1){1'b1}}));
      if (sum_s[EXT_W-1]) begin
        clamp_s = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        clamp_s = {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      oor_s   = |sum_s[EXT_W-1:ACC_W];
      clamp_s = {ACC_W{1'b1}};
    end
    if (SAT && oor_s) begin
      mac_s = clamp_s;
    end else begin
      mac_s = sum_s[ACC_W-1:0];
    end
    if (valid_q) begin
      psum_out_d = mac_s;
    end else begin
      psum_out_d = psum_in_q;
    end
    psum_valid_d = valid_q;
    // A new overflow takes priority over a simultaneous clear.
    if (valid_q && oor_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers; reset drops all in-flight data and the weight bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q     <= {DATA_W{1'b0}};
      for (int i = 0; i < int'(W_DEPTH); i++) begin
        bank_q[i] <= {DATA_W{1'b0}};
      end
      commit_q     <= 1'b0;
      addr_q       <= {SEL_W{1'b0}};
      valid_q      <= 1'b0;
      fm_q         <= {DATA_W{1'b0}};
      sel_q        <= {SEL_W{1'b0}};
      psum_in_q    <= {ACC_W{1'b0}};
      psum_out_q   <= {ACC_W{1'b0}};
      psum_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      shadow_q     <= shadow_d;
      bank_q       <= bank_d;
      commit_q     <= commit_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      fm_q         <= fm_d;
      sel_q        <= sel_d;
      psum_in_q    <= psum_in_d;
      psum_out_q   <= psum_out_d;
      psum_valid_q <= psum_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign w_out          = shadow_q;
  assign w_commit_out   = commit_q;
  assign w_addr_out     = addr_q;
  assign fm_valid_out   = valid_q;
  assign fm_out         = fm_q;
  assign w_sel_out      = sel_q;
  assign psum_out       = psum_out_q;
  assign psum_valid_out = psum_valid_q;
  assign ovf            = ovf_q;

endmodule

// File: tb/tb_pe_2d_mb.sv
// Testbench for pe_2d_mb: a saturating and a wrapping instance (ACC_W=16,
// signed) share all inputs. A behavioural model with integer arithmetic
// predicts every output; directed sequences pin the model with literals.
module tb_pe_2d_mb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        w_load = 1'b0;
  logic [7:0]  w_in = 8'd0;
  logic        w_commit_in = 1'b0;
  logic [1:0]  w_addr_in = 2'd0;
  logic        fm_valid_in = 1'b0;
  logic [7:0]  fm_in = 8'd0;
  logic [1:0]  w_sel_in = 2'd0;
  logic [15:0] psum_in = 16'd0;
  logic        ovf_clr = 1'b0;

  logic [7:0]  w_out_s, w_out_w, fm_out_s, fm_out_w;
  logic        w_commit_out_s, w_commit_out_w, fm_valid_out_s, fm_valid_out_w;
  logic [1:0]  w_addr_out_s, w_addr_out_w, w_sel_out_s, w_sel_out_w;
  logic        psum_valid_out_s, psum_valid_out_w, ovf_s, ovf_w;
  logic [15:0] psum_out_s, psum_out_w;

  int n_vec = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pe_2d_mb #(.DATA_W(8), .ACC_W(16), .W_DEPTH(4), .SIGNED(1'b1), .SAT(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_in(w_in), .w_out(w_out_s),
    .w_commit_in(w_commit_in), .w_addr_in(w_addr_in),
    .w_commit_out(w_commit_out_s), .w_addr_out(w_addr_out_s),
    .fm_valid_in(fm_valid_in), .fm_in(fm_in), .w_sel_in(w_sel_in),
    .fm_valid_out(fm_valid_out_s), .fm_out(fm_out_s), .w_sel_out(w_sel_out_s),
    .psum_in(psum_in), .psum_valid_out(psum_valid_out_s), .psum_out(psum_out_s),
    .ovf_clr(ovf_clr), .ovf(ovf_s));

  pe_2d_mb #(.DATA_W(8), .ACC_W(16), .W_DEPTH(4), .SIGNED(1'b1), .SAT(1'b0)) dut_w (
    .clk(clk), .rst_n(rst_n), .w_load(w_load), .w_in(w_in), .w_out(w_out_w),
    .w_commit_in(w_commit_in), .w_addr_in(w_addr_in),
    .w_commit_out(w_commit_out_w), .w_addr_out(w_addr_out_w),
    .fm_valid_in(fm_valid_in), .fm_in(fm_in), .w_sel_in(w_sel_in),
    .fm_valid_out(fm_valid_out_w), .fm_out(fm_out_w), .w_sel_out(w_sel_out_w),
    .psum_in(psum_in), .psum_valid_out(psum_valid_out_w), .psum_out(psum_out_w),
    .ovf_clr(ovf_clr), .ovf(ovf_w));

  // ---------------- behavioural model ----------------
  logic [7:0]  m_sh = 8'd0;
  logic [7:0]  m_bank [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  logic        m_cout = 1'b0;
  logic [1:0]  m_aout = 2'd0;
  logic        m_v = 1'b0;
  logic [7:0]  m_fm = 8'd0;
  logic [1:0]  m_sel = 2'd0;
  logic [15:0] m_ps = 16'd0;
  logic [15:0] m_sat = 16'd0;
  logic [15:0] m_wrap = 16'd0;
  logic        m_pv = 1'b0;
  logic        m_ovf = 1'b0;

  function automatic longint s8(input logic [7:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint s16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint exact_mac();
    return s16(m_ps) + s8(m_bank[m_sel]) * s8(m_fm);
  endfunction

  function automatic bit out_of_range(input longint x);
    return (x > 32767) || (x < -32768);
  endfunction

  function automatic logic [15:0] clamp16(input longint x);
    if (x > 32767) return 16'h7FFF;
    if (x < -32768) return 16'h8000;
    return 16'(x);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sh <= 8'd0;
      m_bank <= '{8'd0, 8'd0, 8'd0, 8'd0};
      m_cout <= 1'b0; m_aout <= 2'd0;
      m_v <= 1'b0; m_fm <= 8'd0; m_sel <= 2'd0; m_ps <= 16'd0;
      m_sat <= 16'd0; m_wrap <= 16'd0; m_pv <= 1'b0; m_ovf <= 1'b0;
    end else begin
      m_pv   <= m_v;
      m_sat  <= m_v ? clamp16(exact_mac()) : m_ps;
      m_wrap <= m_v ? 16'(exact_mac()) : m_ps;
      m_ovf  <= (m_v && out_of_range(exact_mac())) ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      if (w_commit_in) m_bank[w_addr_in] <= m_sh;
      if (w_load) m_sh <= w_in;
      m_cout <= w_commit_in; m_aout <= w_addr_in;
      m_v <= fm_valid_in; m_fm <= fm_in; m_sel <= w_sel_in; m_ps <= psum_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Compare process: every output against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("w_out", 32'(w_out_s), 32'(m_sh));
      chk("w_commit_out", 32'(w_commit_out_s), 32'(m_cout));
      chk("w_addr_out", 32'(w_addr_out_s), 32'(m_aout));
      chk("fm_valid_out", 32'(fm_valid_out_s), 32'(m_v));
      chk("fm_out", 32'(fm_out_s), 32'(m_fm));
      chk("w_sel_out", 32'(w_sel_out_s), 32'(m_sel));
      chk("psum_out_sat", 32'(psum_out_s), 32'(m_sat));
      chk("psum_valid_sat", 32'(psum_valid_out_s), 32'(m_pv));
      chk("ovf_sat", 32'(ovf_s), 32'(m_ovf));
      chk("w_out_wrap", 32'(w_out_w), 32'(m_sh));
      chk("psum_out_wrap", 32'(psum_out_w), 32'(m_wrap));
      chk("psum_valid_wrap", 32'(psum_valid_out_w), 32'(m_pv));
      chk("ovf_wrap", 32'(ovf_w), 32'(m_ovf));
      chk("fm_out_wrap", 32'(fm_out_w), 32'(m_fm));
    end
  end

  // Drive one cycle of inputs at a falling edge and advance to the next one.
  task automatic apply(input logic v, input logic [7:0] fm, input logic [1:0] sel,
                       input logic [15:0] ps, input logic wl, input logic [7:0] win,
                       input logic wc, input logic [1:0] wa, input logic clr);
    fm_valid_in = v; fm_in = fm; w_sel_in = sel; psum_in = ps;
    w_load = wl; w_in = win; w_commit_in = wc; w_addr_in = wa; ovf_clr = clr;
    @(negedge clk);
  endtask

  task automatic idle();
    apply(1'b0, 8'd0, 2'd0, 16'd0, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic load_commit(input logic [7:0] w, input logic [1:0] a);
    apply(1'b0, 8'd0, 2'd0, 16'd0, 1'b1, w, 1'b0, 2'd0, 1'b0);
    apply(1'b0, 8'd0, 2'd0, 16'd0, 1'b0, 8'd0, 1'b1, a, 1'b0);
  endtask

  task automatic sample(input logic [7:0] fm, input logic [1:0] sel, input logic [15:0] ps);
    apply(1'b1, fm, sel, ps, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
  endtask

  logic [15:0] ms_exp [4];

  initial begin
    ms_exp[0] = 16'h0004; ms_exp[1] = 16'hFFF8; ms_exp[2] = 16'h001C; ms_exp[3] = 16'hFE00;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_psum_out", 32'(psum_out_s), 32'd0);
    chk("rst_psum_valid", 32'(psum_valid_out_s), 32'd0);
    chk("rst_ovf", 32'(ovf_s), 32'd0);
    chk("rst_w_out", 32'(w_out_s), 32'd0);
    chk("rst_fm_valid_out", 32'(fm_valid_out_s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Load and commit, then one MAC: 10 + 3*5 = 25.
    apply(1'b0, 8'd0, 2'd0, 16'd0, 1'b1, 8'd3, 1'b0, 2'd0, 1'b0);
    chk("lc_w_out", 32'(w_out_s), 32'd3);
    chk("lc_commit_idle", 32'(w_commit_out_s), 32'd0);
    apply(1'b0, 8'd0, 2'd0, 16'd0, 1'b0, 8'd0, 1'b1, 2'd2, 1'b0);
    chk("lc_commit_out", 32'(w_commit_out_s), 32'd1);
    chk("lc_addr_out", 32'(w_addr_out_s), 32'd2);
    sample(8'd5, 2'd2, 16'd10);
    chk("lc_fm_out", 32'(fm_out_s), 32'd5);
    chk("lc_commit_pulse", 32'(w_commit_out_s), 32'd0);
    idle();
    chk("lc_psum", 32'(psum_out_s), 32'd25);
    chk("lc_psum_valid", 32'(psum_valid_out_s), 32'd1);

    // Multi-slot: weights {1,-2,7,-128}, fm=4 streamed through slots 0..3.
    load_commit(8'd1, 2'd0);
    load_commit(8'hFE, 2'd1);
    load_commit(8'd7, 2'd2);
    load_commit(8'h80, 2'd3);
    for (int k = 0; k < 5; k++) begin
      if (k < 4) sample(8'd4, 2'(k), 16'd0);
      else idle();
      if (k >= 1) chk("ms_psum", 32'(psum_out_s), 32'(ms_exp[k-1]));
    end

    // Bubble: psum passes through untouched.
    apply(1'b0, 8'h11, 2'd1, 16'd123, 1'b0, 8'd0, 1'b0, 2'd0, 1'b0);
    chk("bub_fm_valid_out", 32'(fm_valid_out_s), 32'd0);
    idle();
    chk("bub_psum", 32'(psum_out_s), 32'd123);
    chk("bub_psum_valid", 32'(psum_valid_out_s), 32'd0);

    // Saturation vs wrap: 32000 + 127*127 = 48129.
    load_commit(8'd127, 2'd0);
    sample(8'd127, 2'd0, 16'd32000);
    idle();
    chk("sat_psum", 32'(psum_out_s), 32'h7FFF);
    chk("wrap_psum", 32'(psum_out_w), 32'hBC01);
    chk("sat_ovf", 32'(ovf_s), 32'd1);
    chk("wrap_ovf", 32'(ovf_w), 32'd1);
    idle(); idle();
    chk("ovf_sticky", 32'(ovf_s), 32'd1);
    apply(1'b0, 8'd0, 2'd0, 16'd0, 1'b0, 8'd0, 1'b0, 2'd0, 1'b1);
    chk("ovf_cleared", 32'(ovf_s), 32'd0);
    sample(8'd127, 2'd0, 16'd32000);
    apply(1'b0, 8'd0, 2'd0, 16'd0, 1'b0, 8'd0, 1'b0, 2'd0, 1'b1);
    chk("ovf_set_wins", 32'(ovf_s), 32'd1);
    apply(1'b0, 8'd0, 2'd0, 16'd0, 1'b0, 8'd0, 1'b0, 2'd0, 1'b1);
    chk("ovf_clr_again", 32'(ovf_s), 32'd0);

    // Commit/read collision: old weight 2 used, then new weight 9.
    load_commit(8'd2, 2'd1);
    apply(1'b0, 8'd0, 2'd0, 16'd0, 1'b1, 8'd9, 1'b0, 2'd0, 1'b0);
    sample(8'd1, 2'd1, 16'd0);
    apply(1'b1, 8'd1, 2'd1, 16'd0, 1'b0, 8'd0, 1'b1, 2'd1, 1'b0);
    chk("col_old_weight", 32'(psum_out_s), 32'd2);
    idle();
    chk("col_new_weight", 32'(psum_out_s), 32'd9);

    // Asynchronous reset between edges with a sample in flight.
    sample(8'd3, 2'd1, 16'd5);
    fm_valid_in = 1'b0; fm_in = 8'd0; w_sel_in = 2'd0; psum_in = 16'd0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_fm_valid_out", 32'(fm_valid_out_s), 32'd0);
    chk("arst_fm_out", 32'(fm_out_s), 32'd0);
    chk("arst_w_out", 32'(w_out_s), 32'd0);
    chk("arst_psum", 32'(psum_out_s), 32'd0);
    chk("arst_psum_wrap", 32'(psum_out_w), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    sample(8'd5, 2'd1, 16'd7);
    idle();
    chk("arst_weight_zero", 32'(psum_out_s), 32'd7);
    chk("arst_valid", 32'(psum_valid_out_s), 32'd1);

    // Randomized traffic checked by the compare process.
    for (int n = 0; n < 600; n++) begin
      apply(($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom), 16'($urandom),
            1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom),
            ($urandom_range(0, 9) == 0));
    end
    idle(); idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
